// File: rtl/axis_i2c_arbiter.sv
// Round-robin, packet-locked arbiter that lets N_PORTS AXI-Stream command
// requesters share one I2C master. Pure combinational passthrough while a packet is active.
package i2c_pkg;
  localparam int AXIS_DATA_WIDTH = 8;
endpackage

module axis_i2c_arb_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  gnt_i,
  input  logic                  active_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tlast_i,
  input  logic                  m_tready_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  output logic                  m_tlast_o
);
  logic sel;

  // Non-selected lanes contribute zeros so the top can OR all lanes together.
  assign sel        = gnt_i & active_i;
  assign s_tready_o = sel & m_tready_i;
  assign m_tdata_o  = sel ? s_tdata_i : '0;
  assign m_tvalid_o = sel & s_tvalid_i;
  assign m_tlast_o  = sel & s_tlast_i;
endmodule

module axis_i2c_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = i2c_pkg::AXIS_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [N_PORTS-1:0]            s_tvalid_i,
  input  logic [N_PORTS-1:0]            s_tlast_i,
  output logic [N_PORTS-1:0]            s_tready_o,
  output logic [DATA_WIDTH-1:0]         m_tdata_o,
  output logic                          m_tvalid_o,
  output logic                          m_tlast_o,
  input  logic                          m_tready_i,
  output logic [N_PORTS-1:0]            grant_o,
  output logic                          busy_o,
  output logic [CNT_WIDTH-1:0]          pkt_cnt_o
);
  localparam int IDXW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                                state_q, state_d;
  logic [N_PORTS-1:0]                    grant_q, grant_d;
  logic [IDXW-1:0]                       last_q, last_d;
  logic [CNT_WIDTH-1:0]                  cnt_q, cnt_d;
  logic [IDXW-1:0]                       win_idx;
  logic                                  win_found;
  logic                                  active;
  logic                                  last_xfer;

  logic [N_PORTS-1:0][DATA_WIDTH-1:0]    lane_data;
  logic [N_PORTS-1:0]                    lane_valid;
  logic [N_PORTS-1:0]                    lane_last;

  assign active = (state_q == ACTIVE);

  for (genvar k = 0; k < N_PORTS; k++) begin : g_lane
    axis_i2c_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .gnt_i      (grant_q[k]),
      .active_i   (active),
      .s_tdata_i  (s_tdata_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .s_tvalid_i (s_tvalid_i[k]),
      .s_tlast_i  (s_tlast_i[k]),
      .m_tready_i (m_tready_i),
      .s_tready_o (s_tready_o[k]),
      .m_tdata_o  (lane_data[k]),
      .m_tvalid_o (lane_valid[k]),
      .m_tlast_o  (lane_last[k])
    );
  end

  always_comb begin
    m_tdata_o = '0;
    for (int k = 0; k < N_PORTS; k++) m_tdata_o = m_tdata_o | lane_data[k];
  end

  assign m_tvalid_o = |lane_valid;
  assign m_tlast_o  = |lane_last;
  assign last_xfer  = m_tvalid_o & m_tready_i & m_tlast_o;

  // Search starts one past the previous winner and wraps, so the previous
  // winner itself is examined last.
  always_comb begin
    logic [IDXW:0] cand;
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      cand = {1'b0, last_q} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(N_PORTS)) cand = cand - (IDXW+1)'(N_PORTS);
      if (!win_found && s_tvalid_i[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
          state_d          = ACTIVE;
        end
      end
      ACTIVE: begin
        if (last_xfer) begin
          grant_d = '0;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDXW'(N_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = active;
  assign pkt_cnt_o = cnt_q;
endmodule

// File: doc/axis_i2c_arbiter.md
AXIS_I2C_ARBITER -- requirements
Module: axis_i2c_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4, number of AXI-Stream command requesters sharing one I2C master; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default AXIS_DATA_WIDTH from i2c_pkg, width of tdata on all ports.
REQ-003 Parameter CNT_WIDTH, default 16, width of the completed-packet counter.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rstn_i  input  1  synchronous active-low reset.
REQ-007 s_tdata_i  input  N_PORTS*DATA_WIDTH  requester data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 s_tvalid_i  input  N_PORTS  requester valid, one bit per port.
REQ-009 s_tlast_i  input  N_PORTS  requester end-of-packet, one bit per port.
REQ-010 s_tready_o  output  N_PORTS  requester ready, one bit per port.
REQ-011 m_tdata_o  output  DATA_WIDTH  data toward I2C master.
REQ-012 m_tvalid_o  output  1  valid toward I2C master.
REQ-013 m_tlast_o  output  1  end-of-packet toward I2C master.
REQ-014 m_tready_i  input  1  ready from I2C master.
REQ-015 grant_o  output  N_PORTS  one-hot current owner; all-zero when idle.
REQ-016 busy_o  output  1  high while a packet is being forwarded.
REQ-017 pkt_cnt_o  output  CNT_WIDTH  count of completed packets.

Function
REQ-018 FSM SHALL have two states: IDLE and ACTIVE.
REQ-019 IDLE: grant_o = 0, m_tvalid_o = 0, s_tready_o = 0, busy_o = 0.
REQ-020 IDLE with any s_tvalid_i high: register the winner into grant_o and enter ACTIVE next cycle; first beat forwardable one cycle after request is seen (1-cycle arbitration latency).
REQ-021 Winner: round-robin; search starts at port (last_grant+1) mod N_PORTS, wraps, and takes the first port with tvalid high.
REQ-022 last_grant updates to the winner index at the grant; resets to N_PORTS-1, so port 0 has first priority after reset.
REQ-023 ACTIVE: m_tdata_o/m_tvalid_o/m_tlast_o = granted port's signals; s_tready_o[g] = m_tready_i; all other s_tready_o bits 0; combinational passthrough, no buffering.
REQ-024 Grant is locked for the whole packet; requests from other ports SHALL NOT change grant_o until the tlast beat completes.
REQ-025 Beat transfers when m_tvalid_o && m_tready_i; the beat with m_tlast_o = 1 returns FSM to IDLE next cycle and increments pkt_cnt_o by 1.
REQ-026 pkt_cnt_o wraps from 2^CNT_WIDTH-1 to 0 without flag.
REQ-027 Granted port deasserting tvalid mid-packet SHALL NOT release the grant; arbiter waits.
REQ-028 Single-beat packet (tvalid and tlast on first beat) SHALL take exactly one ACTIVE cycle when m_tready_i = 1.
REQ-029 Back-to-back: after return to IDLE, re-arbitration costs one idle cycle; throughput max is one packet per (beats+1) cycles.
REQ-030 m_tdata_o in IDLE SHALL be 0.
REQ-031 Lone requester SHALL be regranted repeatedly; round-robin affects only contention.

Reset
REQ-032 With rstn_i low at a clock edge: state IDLE, grant_o = 0, busy_o = 0, m_tvalid_o = 0, s_tready_o = 0, pkt_cnt_o = 0, last_grant = N_PORTS-1.
REQ-033 Reset mid-packet SHALL abort the transfer immediately; no tlast is emitted and pkt_cnt_o is not incremented; packet remainder is the requester's concern.
REQ-034 Outputs SHALL hold reset values for the cycle following any cycle with rstn_i low.

Verification
REQ-035 After reset, ports 0 and 2 both valid with 3-beat packets (0xA0,0xA1,0xA2 / 0xC0,0xC1,0xC2), m_tready_i = 1 -> port 0 packet forwarded first, one idle cycle, then port 2; pkt_cnt_o = 2.
REQ-036 All 4 ports continuously valid with single-beat packets -> grant order 0,1,2,3,0; each grant lasts one cycle, separated by one IDLE cycle.
REQ-037 Port 1 granted; m_tready_i low 5 cycles mid-packet while port 3 raises tvalid -> grant_o stays 0b0010, data held stable, s_tready_o[3] = 0 throughout.
REQ-038 Port 0 drops tvalid 3 cycles between beats 1 and 2 -> grant held, m_tvalid_o = 0 during gap, packet completes, pkt_cnt_o += 1.
REQ-039 rstn_i asserted on beat 2 of a 4-beat packet -> next cycle all outputs at reset values, pkt_cnt_o = 0; following arbitration begins at port 0.
REQ-040 pkt_cnt_o preloaded near wrap via 65536 single-beat packets (CNT_WIDTH = 16) -> counter reads 0 after the 65536th.
